burst_delay_memory: RTL and testbench

- Parametrised, single-ported main-memory model with programmable access latency and wrapping burst transfers.
- Latches a command, waits DELAY_CYCLES, then streams BURST_LEN beats with MEM_VALID asserted, starting at the requested word and wrapping within the aligned burst.
- Sits behind the cache and memory controller as the backing store for the multi-cycle-memory OTTER labs.
- Generalises the earlier fixed delay memory:
  - width and depth are parameters;
  - commands are latched rather than held;
  - beats walk the burst address;
  - writes commit on the rising edge;
  - illegal requests are flagged.

---
 rtl/burst_delay_memory_if.sv | 38 +++
 rtl/burst_delay_memory.sv | 146 ++++++++++++++
 tb/tb_burst_delay_memory.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/burst_delay_memory_if.sv
// burst_delay_memory_if: command/beat bus between a memory controller and burst_delay_memory.
// Latency: n/a (wires only); first beat DELAY_CYCLES edges after accept, set by the slave.
// Backpressure: none; the master watches BUSY and must hold off new commands while it is high.
// Signals: RE/WE/ADDR/DATA_IN (+BE when BURST_DELAY_MEM_BYTE_EN_EN) master->slave;
//          MEM_VALID/DATA_OUT/BEAT_LAST/BUSY/ERR slave->master.
interface burst_delay_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    RE;
    logic                    WE;
    logic [ADDR_WIDTH-1:0]   ADDR;
    logic [DATA_WIDTH-1:0]   DATA_IN;
`ifdef BURST_DELAY_MEM_BYTE_EN_EN
    logic [DATA_WIDTH/8-1:0] BE;
`endif
    logic                    MEM_VALID;
    logic [DATA_WIDTH-1:0]   DATA_OUT;
    logic                    BEAT_LAST;
    logic                    BUSY;
    logic                    ERR;

    modport master (
        output RE, WE, ADDR, DATA_IN,
`ifdef BURST_DELAY_MEM_BYTE_EN_EN
        output BE,
`endif
        input  MEM_VALID, DATA_OUT, BEAT_LAST, BUSY, ERR
    );

    modport slave (
        input  RE, WE, ADDR, DATA_IN,
`ifdef BURST_DELAY_MEM_BYTE_EN_EN
        input  BE,
`endif
        output MEM_VALID, DATA_OUT, BEAT_LAST, BUSY, ERR
    );
endinterface

// File: rtl/burst_delay_memory.sv
// burst_delay_memory: single-ported backing-store model with programmable delay and wrapping bursts.
// Latency: command accepted at edge k, beats valid from edge k+DELAY_CYCLES for BURST_LEN cycles.
// Backpressure: none; commands arriving while BUSY are dropped, RE&WE in IDLE pulses ERR.
// Ports: CLK, RST_N (async active-low), bus (burst_delay_memory_if.slave).
// Optional: define BURST_DELAY_MEM_BYTE_EN_EN to add per-beat byte-lane enables (bus.BE).
// The array has no reset; INIT_FILE names the hex image the surrounding harness preloads.
module burst_delay_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 16384,
    parameter int DELAY_CYCLES = 10,
    parameter int BURST_LEN    = 4,
    parameter     INIT_FILE    = "otter_memory.mem"
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    burst_delay_memory_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BOFF  = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int WIDX  = $clog2(DEPTH);
    localparam int DCW   = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int BCW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WIDX-1:0]       BURST_MASK = WIDX'(BURST_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] IDLE_PAT   = DATA_WIDTH'(32'hDEADBEEF);
    // The image name is not consumed by the RTL itself.
    localparam int unused_init_bits = $bits(INIT_FILE);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_BURST = 2'd2} state_t;

    state_t                r_state;
    logic [DCW-1:0]        r_dly;
    logic [BCW-1:0]        r_beat;
    logic [WIDX-1:0]       r_base;
    logic [WIDX-1:0]       r_offset;
    logic                  r_is_wr;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [WIDX-1:0]       w_word_idx;
    logic [WIDX-1:0]       w_sum;
    logic [WIDX-1:0]       w_beat_addr;
    logic [BYTES-1:0]      w_lane_en;
    logic                  w_unused_addr;

    // Upper address bits alias; byte-offset bits select nothing in a word-wide array.
    assign w_word_idx    = bus.ADDR[WIDX+BOFF-1:BOFF];
    assign w_unused_addr = ^bus.ADDR;

    // Critical word first: the offset walks forward and wraps inside the aligned block.
    assign w_sum       = r_offset + WIDX'(r_beat);
    assign w_beat_addr = r_base | (w_sum & BURST_MASK);

`ifdef BURST_DELAY_MEM_BYTE_EN_EN
    assign w_lane_en = bus.BE;
`else
    assign w_lane_en = '1;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_dly    <= '0;
            r_beat   <= '0;
            r_base   <= '0;
            r_offset <= '0;
            r_is_wr  <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= bus.RE & bus.WE;
                    if (bus.RE ^ bus.WE) begin
                        r_is_wr  <= bus.WE;
                        r_base   <= w_word_idx & ~BURST_MASK;
                        r_offset <= w_word_idx & BURST_MASK;
                        r_beat   <= '0;
                        r_dly    <= '0;
                        r_busy   <= 1'b1;
                        if (DELAY_CYCLES == 0) begin
                            r_state <= S_BURST;
                            r_valid <= 1'b1;
                            r_last  <= (BURST_LEN == 1);
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_err <= 1'b0;
                    r_dly <= r_dly + 1'b1;
                    // r_dly holds the number of edges already spent since accept, minus one.
                    if (r_dly == DCW'(DELAY_CYCLES - 1)) begin
                        r_state <= S_BURST;
                        r_valid <= 1'b1;
                        r_last  <= (BURST_LEN == 1);
                    end
                end
                S_BURST: begin
                    r_err <= 1'b0;
                    if (r_beat == BCW'(BURST_LEN - 1)) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_beat  <= '0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                        r_last <= (BCW'(r_beat + 1'b1) == BCW'(BURST_LEN - 1));
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Write beats commit on the edge that ends them; a reset clears r_valid
    // asynchronously, so an aborted burst writes nothing further.
    always_ff @(posedge CLK) begin
        if (r_valid && r_is_wr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_lane_en[b]) begin
                    r_mem[w_beat_addr][8*b +: 8] <= bus.DATA_IN[8*b +: 8];
                end
            end
        end
    end

    assign bus.DATA_OUT  = r_valid ? r_mem[w_beat_addr] : IDLE_PAT;
    assign bus.MEM_VALID = r_valid;
    assign bus.BEAT_LAST = r_last;
    assign bus.BUSY      = r_busy;
    assign bus.ERR       = r_err;
endmodule

// File: tb/tb_burst_delay_memory.sv
// tb_burst_delay_memory: directed bench for burst_delay_memory (10-cycle/4-beat and 0-cycle/1-beat builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_burst_delay_memory;
    logic CLK = 1'b0;
    logic RST_N;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    burst_delay_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
    burst_delay_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();

    burst_delay_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256),
        .DELAY_CYCLES(10), .BURST_LEN(4), .INIT_FILE("")
    ) dut_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (ifa)
    );

    burst_delay_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256),
        .DELAY_CYCLES(0), .BURST_LEN(1), .INIT_FILE("")
    ) dut_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (ifb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid_a(input string tag);
        int n = 0;
        while (ifa.MEM_VALID !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check({tag, "_valid_seen"}, 32'(ifa.MEM_VALID), 32'd1);
    endtask

    task automatic write_a(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input string tag);
        logic [31:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        ifa.WE   = 1'b1;
        ifa.ADDR = addr;
        step();
        ifa.WE = 1'b0;
        wait_valid_a(tag);
        for (int i = 0; i < 4; i++) begin
            ifa.DATA_IN = d[i];
            step();
        end
        check({tag, "_busy_done"}, 32'(ifa.BUSY), 32'd0);
    endtask

    task automatic read_a(input logic [31:0] addr, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3, input string tag);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        ifa.RE   = 1'b1;
        ifa.ADDR = addr;
        step();
        ifa.RE = 1'b0;
        wait_valid_a(tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_d%0d", tag, i), ifa.DATA_OUT, e[i]);
            check($sformatf("%s_last%0d", tag, i), 32'(ifa.BEAT_LAST), (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        check({tag, "_valid_end"}, 32'(ifa.MEM_VALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N       = 1'b0;
        ifa.RE      = 1'b1;
        ifa.WE      = 1'b0;
        ifa.ADDR    = 32'h10;
        ifa.DATA_IN = '0;
        ifb.RE      = 1'b0;
        ifb.WE      = 1'b0;
        ifb.ADDR    = '0;
        ifb.DATA_IN = '0;
`ifdef BURST_DELAY_MEM_BYTE_EN_EN
        ifa.BE = '1;
        ifb.BE = '1;
`endif
        #1;

        // Reset held for three edges with RE asserted: nothing is accepted.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst%0d_valid", i), 32'(ifa.MEM_VALID), 32'd0);
            check($sformatf("rst%0d_busy", i),  32'(ifa.BUSY),      32'd0);
            check($sformatf("rst%0d_last", i),  32'(ifa.BEAT_LAST), 32'd0);
            check($sformatf("rst%0d_err", i),   32'(ifa.ERR),       32'd0);
        end
        check("rst_dout_idle", ifa.DATA_OUT, 32'hDEADBEEF);
        ifa.RE = 1'b0;
        RST_N  = 1'b1;
        step();
        check("post_rst_busy", 32'(ifa.BUSY), 32'd0);

        // Image: words 4..7 = A,B,C,D.
        write_a(32'h10, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D, "load");

        // One-cycle RE at 0x18 (word 6): ten idle cycles, then C,D,A,B.
        ifa.RE   = 1'b1;
        ifa.ADDR = 32'h18;
        step();
        ifa.RE = 1'b0;
        check("lat_busy", 32'(ifa.BUSY), 32'd1);
        check("lat_wait0", 32'(ifa.MEM_VALID), 32'd0);
        for (int i = 1; i < 10; i++) begin
            step();
            check($sformatf("lat_wait%0d", i), 32'(ifa.MEM_VALID), 32'd0);
        end
        step();
        check("rd18_v0", 32'(ifa.MEM_VALID), 32'd1);
        check("rd18_d0", ifa.DATA_OUT, 32'h0C0C0C0C);
        check("rd18_l0", 32'(ifa.BEAT_LAST), 32'd0);
        step();
        check("rd18_d1", ifa.DATA_OUT, 32'h0D0D0D0D);
        check("rd18_l1", 32'(ifa.BEAT_LAST), 32'd0);
        step();
        check("rd18_d2", ifa.DATA_OUT, 32'h0A0A0A0A);
        check("rd18_l2", 32'(ifa.BEAT_LAST), 32'd0);
        step();
        check("rd18_d3", ifa.DATA_OUT, 32'h0B0B0B0B);
        check("rd18_l3", 32'(ifa.BEAT_LAST), 32'd1);
        check("rd18_busy3", 32'(ifa.BUSY), 32'd1);
        step();
        check("rd18_v_end", 32'(ifa.MEM_VALID), 32'd0);
        check("rd18_busy_end", 32'(ifa.BUSY), 32'd0);
        check("rd18_dout_end", ifa.DATA_OUT, 32'hDEADBEEF);

        // Write then read back a burst at 0x40.
        write_a(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, "wr40");
        read_a(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, "rd40");

        // RE and WE together in IDLE: ERR for exactly one cycle, no accept.
        ifa.RE      = 1'b1;
        ifa.WE      = 1'b1;
        ifa.ADDR    = 32'h40;
        ifa.DATA_IN = 32'hFFFFFFFF;
        step();
        ifa.RE = 1'b0;
        ifa.WE = 1'b0;
        check("err_pulse", 32'(ifa.ERR), 32'd1);
        check("err_busy", 32'(ifa.BUSY), 32'd0);
        step();
        check("err_clear", 32'(ifa.ERR), 32'd0);
        check("err_busy2", 32'(ifa.BUSY), 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("err_no_valid", 32'(ifa.MEM_VALID), 32'd0);
        read_a(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, "rd40_after_err");

        // Reset during beat 2 of a write to 0x80: beats 0,1 land, 2,3 keep old data.
        write_a(32'h80, 32'h50, 32'h51, 32'h52, 32'h53, "pre80");
        ifa.WE   = 1'b1;
        ifa.ADDR = 32'h80;
        step();
        ifa.WE = 1'b0;
        wait_valid_a("ab80");
        ifa.DATA_IN = 32'h60;
        step();
        ifa.DATA_IN = 32'h61;
        step();
        ifa.DATA_IN = 32'h62;
        RST_N = 1'b0;
        #1;
        check("ab_valid", 32'(ifa.MEM_VALID), 32'd0);
        check("ab_busy", 32'(ifa.BUSY), 32'd0);
        check("ab_last", 32'(ifa.BEAT_LAST), 32'd0);
        step();
        step();
        RST_N = 1'b1;
        step();
        check("ab_idle_busy", 32'(ifa.BUSY), 32'd0);
        read_a(32'h80, 32'h60, 32'h61, 32'h52, 32'h53, "rd80");

        // Zero delay, single-beat build: write word 2, then read 0x8.
        ifb.WE      = 1'b1;
        ifb.ADDR    = 32'h8;
        ifb.DATA_IN = 32'h22222222;
        step();
        ifb.WE = 1'b0;
        check("b_wr_valid", 32'(ifb.MEM_VALID), 32'd1);
        check("b_wr_last", 32'(ifb.BEAT_LAST), 32'd1);
        step();
        check("b_wr_done", 32'(ifb.MEM_VALID), 32'd0);
        check("b_wr_busy", 32'(ifb.BUSY), 32'd0);
        ifb.DATA_IN = 32'h0;
        ifb.RE      = 1'b1;
        ifb.ADDR    = 32'h8;
        step();
        ifb.RE = 1'b0;
        check("b_rd_valid", 32'(ifb.MEM_VALID), 32'd1);
        check("b_rd_data", ifb.DATA_OUT, 32'h22222222);
        check("b_rd_last", 32'(ifb.BEAT_LAST), 32'd1);
        check("b_rd_busy", 32'(ifb.BUSY), 32'd1);
        step();
        check("b_rd_end", 32'(ifb.MEM_VALID), 32'd0);
        check("b_rd_dout_idle", ifb.DATA_OUT, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
